bht_updater: RTL and testbench

BHT_UPDATER -- requirements
Module: bht_updater

---
 rtl/bp_pkg.sv | 21 ++
 rtl/sat_counter2.sv | 22 ++
 rtl/bht_updater.sv | 107 ++++++++++
 tb/tb_bht_updater.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: BHT/GHR widths and 2-bit counter encodings.
package bp_pkg;

  localparam int BHT_IDX_W = 10;
  localparam int GHR_W     = 8;
  localparam int PC_W      = 32;
  localparam int STAT_W    = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  // The counter MSB is the taken/not-taken prediction the front end acted on.
  function automatic logic predicted_taken(input logic [1:0] state);
    return state[1];
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Combinational 2-bit saturating counter: steps toward ST on taken, toward SNT otherwise.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] i_state,
  input  logic       i_taken,
  output logic [1:0] o_next
);

  // NOTE: default assignment first so every path drives o_next and no latch is inferred.
  always_comb begin
    o_next = i_state;
    unique case (bht_state_e'(i_state))
      SNT: o_next = i_taken ? WNT : SNT;
      WNT: o_next = i_taken ? WT  : SNT;
      WT:  o_next = i_taken ? ST  : WNT;
      ST:  o_next = i_taken ? ST  : WT;
      default: o_next = i_state;
    endcase
  end

endmodule

// File: rtl/bht_updater.sv
// BHT write-back stage: registered counter update, GHR commit and mispredict recovery.
// Optional BHT_STATS_EN adds br_cnt / mispred_cnt statistics outputs.
module bht_updater
  import bp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  input  logic                 stall,
  input  logic [PC_W-1:0]      ex_pc,
  input  logic [1:0]           ex_old_bht,
  input  logic [GHR_W-1:0]     ex_old_pattern,
  input  logic                 ex_taken,
  output logic                 upd_valid,
  output logic [BHT_IDX_W-1:0] upd_addr,
  output logic [1:0]           upd_bht,
  output logic [GHR_W-1:0]     ghr,
  output logic                 mispredict,
`ifdef BHT_STATS_EN
  output logic [STAT_W-1:0]    br_cnt,
  output logic [STAT_W-1:0]    mispred_cnt,
`endif
  output logic [GHR_W-1:0]     recover_pattern
);

  logic                 r_upd_valid;
  logic [BHT_IDX_W-1:0] r_upd_addr;
  logic [1:0]           r_upd_bht;
  logic [GHR_W-1:0]     r_ghr;
  logic                 r_mispredict;
  logic [GHR_W-1:0]     r_recover_pattern;

  logic                 w_accept;
  logic [BHT_IDX_W-1:0] w_idx;
  logic                 w_bypass;
  logic [1:0]           w_base;
  logic [1:0]           w_next;
  logic                 w_mispred;

  assign w_accept  = ex_valid & ~stall;
  assign w_idx     = ex_pc[BHT_IDX_W:1];

  // The counter read at fetch is stale if the previous cycle wrote the same entry.
  assign w_bypass  = r_upd_valid && (w_idx == r_upd_addr);
  assign w_base    = w_bypass ? r_upd_bht : ex_old_bht;

  // Mispredict is judged against what fetch actually saw, never the bypassed value.
  assign w_mispred = predicted_taken(ex_old_bht) != ex_taken;

  sat_counter2 u_sat (
    .i_state (w_base),
    .i_taken (ex_taken),
    .o_next  (w_next)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upd_valid       <= 1'b0;
      r_upd_addr        <= '0;
      r_upd_bht         <= SNT;
      r_ghr             <= '0;
      r_mispredict      <= 1'b0;
      r_recover_pattern <= '0;
    end else begin
      r_upd_valid  <= w_accept;
      r_mispredict <= w_accept & w_mispred;
      if (w_accept) begin
        r_upd_addr <= w_idx;
        r_upd_bht  <= w_next;
        r_ghr      <= {r_ghr[GHR_W-2:0], ex_taken};
        if (w_mispred) begin
          r_recover_pattern <= {ex_old_pattern[GHR_W-2:0], ex_taken};
        end
      end
    end
  end

`ifdef BHT_STATS_EN
  logic [STAT_W-1:0] r_br_cnt;
  logic [STAT_W-1:0] r_mispred_cnt;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
    end else if (w_accept) begin
      r_br_cnt <= r_br_cnt + 1'b1;
      if (w_mispred) begin
        r_mispred_cnt <= r_mispred_cnt + 1'b1;
      end
    end
  end

  assign br_cnt      = r_br_cnt;
  assign mispred_cnt = r_mispred_cnt;
`endif

  assign upd_valid       = r_upd_valid;
  assign upd_addr        = r_upd_addr;
  assign upd_bht         = r_upd_bht;
  assign ghr             = r_ghr;
  assign mispredict      = r_mispredict;
  assign recover_pattern = r_recover_pattern;

endmodule

// File: tb/tb_bht_updater.sv
// Self-checking bench for bht_updater: directed vector table, reset corner cases, random vs model.
module tb_bht_updater;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [1:0]  ex_old_bht = '0;
  logic [7:0]  ex_old_pattern = '0;
  logic        ex_taken = 1'b0;
  logic        upd_valid;
  logic [9:0]  upd_addr;
  logic [1:0]  upd_bht;
  logic [7:0]  ghr;
  logic        mispredict;
  logic [7:0]  recover_pattern;
`ifdef BHT_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state, kept as plain integers.
  int m_valid, m_addr, m_bht, m_ghr, m_mis, m_rec;
  int m_br, m_mp;

  bht_updater dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_valid        (ex_valid),
    .stall           (stall),
    .ex_pc           (ex_pc),
    .ex_old_bht      (ex_old_bht),
    .ex_old_pattern  (ex_old_pattern),
    .ex_taken        (ex_taken),
    .upd_valid       (upd_valid),
    .upd_addr        (upd_addr),
    .upd_bht         (upd_bht),
    .ghr             (ghr),
    .mispredict      (mispredict),
`ifdef BHT_STATS_EN
    .br_cnt          (br_cnt),
    .mispred_cnt     (mispred_cnt),
`endif
    .recover_pattern (recover_pattern)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_addr = 0; m_bht = 0; m_ghr = 0; m_mis = 0; m_rec = 0;
    m_br = 0; m_mp = 0;
  endtask

  // Applies one cycle of inputs, advances the model, and leaves outputs settled #1 after the edge.
  task automatic apply(input logic v, input logic s, input logic [31:0] pc,
                       input logic [1:0] bht, input logic [7:0] pat, input logic tk);
    int idx, base, nb, mis;
    ex_valid = v; stall = s; ex_pc = pc; ex_old_bht = bht;
    ex_old_pattern = pat; ex_taken = tk;
    idx = (pc / 2) % 1024;
    mis = ((bht >= 2) != tk) ? 1 : 0;
    if (v && !s) begin
      base = (m_valid != 0 && idx == m_addr) ? m_bht : int'(bht);
      nb   = tk ? ((base + 1 > 3) ? 3 : base + 1) : ((base - 1 < 0) ? 0 : base - 1);
      m_addr = idx; m_bht = nb;
      m_ghr  = (m_ghr * 2 + int'(tk)) % 256;
      if (mis != 0) m_rec = ((pat % 128) * 2) + int'(tk);
      m_valid = 1; m_mis = mis;
      m_br++; if (mis != 0) m_mp++;
    end else begin
      m_valid = 0; m_mis = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".upd_valid"}, 32'(upd_valid), 32'(m_valid));
    check({tag, ".upd_addr"}, 32'(upd_addr), 32'(m_addr));
    check({tag, ".upd_bht"}, 32'(upd_bht), 32'(m_bht));
    check({tag, ".mispredict"}, 32'(mispredict), 32'(m_mis));
    check({tag, ".ghr"}, 32'(ghr), 32'(m_ghr));
    check({tag, ".recover"}, 32'(recover_pattern), 32'(m_rec));
`ifdef BHT_STATS_EN
    check({tag, ".br_cnt"}, br_cnt, 32'(m_br));
    check({tag, ".mispred_cnt"}, mispred_cnt, 32'(m_mp));
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".upd_valid"}, 32'(upd_valid), 32'h0);
    check({tag, ".upd_addr"}, 32'(upd_addr), 32'h0);
    check({tag, ".upd_bht"}, 32'(upd_bht), 32'h0);
    check({tag, ".mispredict"}, 32'(mispredict), 32'h0);
    check({tag, ".ghr"}, 32'(ghr), 32'h0);
    check({tag, ".recover"}, 32'(recover_pattern), 32'h0);
`ifdef BHT_STATS_EN
    check({tag, ".br_cnt"}, br_cnt, 32'h0);
    check({tag, ".mispred_cnt"}, mispred_cnt, 32'h0);
`endif
  endtask

  typedef struct {
    logic        v;
    logic        s;
    logic [31:0] pc;
    logic [1:0]  bht;
    logic [7:0]  pat;
    logic        tk;
    logic        e_v;
    logic [9:0]  e_addr;
    logic [1:0]  e_bht;
    logic        e_mis;
    logic [7:0]  e_ghr;
    logic [7:0]  e_rec;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // Sequence from reset; expected values worked out by hand from the counter rules.
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 2'b11, 8'h00, 1'b1, 1'b1, 10'h080, 2'b11, 1'b0, 8'h01, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0300, 2'b10, 8'h5A, 1'b0, 1'b1, 10'h180, 2'b01, 1'b1, 8'h02, 8'hB4};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0200, 2'b00, 8'h00, 1'b1, 1'b0, 10'h180, 2'b01, 1'b0, 8'h02, 8'hB4};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0200, 2'b00, 8'h00, 1'b1, 1'b1, 10'h100, 2'b01, 1'b1, 8'h05, 8'h01};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0200, 2'b00, 8'h00, 1'b1, 1'b1, 10'h100, 2'b10, 1'b1, 8'h0B, 8'h01};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0200, 2'b00, 8'h00, 1'b1, 1'b0, 10'h100, 2'b10, 1'b0, 8'h0B, 8'h01};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0202, 2'b01, 8'hFF, 1'b0, 1'b1, 10'h101, 2'b00, 1'b0, 8'h16, 8'h01};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0202, 2'b11, 8'h80, 1'b0, 1'b1, 10'h101, 2'b00, 1'b1, 8'h2C, 8'h00};
    vecs[8] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 2'b11, 8'h00, 1'b1, 1'b1, 10'h3FF, 2'b11, 1'b0, 8'h59, 8'h00};

    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      apply(vecs[i].v, vecs[i].s, vecs[i].pc, vecs[i].bht, vecs[i].pat, vecs[i].tk);
      check({tag, ".upd_valid"}, 32'(upd_valid), 32'(vecs[i].e_v));
      check({tag, ".upd_addr"}, 32'(upd_addr), 32'(vecs[i].e_addr));
      check({tag, ".upd_bht"}, 32'(upd_bht), 32'(vecs[i].e_bht));
      check({tag, ".mispredict"}, 32'(mispredict), 32'(vecs[i].e_mis));
      check({tag, ".ghr"}, 32'(ghr), 32'(vecs[i].e_ghr));
      check({tag, ".recover"}, 32'(recover_pattern), 32'(vecs[i].e_rec));
`ifdef BHT_STATS_EN
      check({tag, ".br_cnt"}, br_cnt, 32'(m_br));
      check({tag, ".mispred_cnt"}, mispred_cnt, 32'(m_mp));
`endif
    end

    // Eight accepted taken branches fill the history with ones.
    for (int i = 0; i < 8; i++) apply(1'b1, 1'b0, 32'h40 + 32'(i * 4), 2'b11, 8'h00, 1'b1);
    check("ghr_all_taken", 32'(ghr), 32'hFF);
    compare_model("taken8");

    // Asynchronous reset mid-cycle, with an acceptable update on the inputs.
    ex_valid = 1'b1; stall = 1'b0; ex_pc = 32'h0000_0010; ex_old_bht = 2'b10; ex_taken = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    @(negedge clk);
    ex_valid = 1'b0;
    rst_n = 1'b1;
    apply(1'b0, 1'b0, 32'h0, 2'b00, 8'h00, 1'b0);
    check("no_write_after_rst", 32'(upd_valid), 32'h0);

    // First update after reset must not bypass from the cleared upd_bht (SNT at index 0).
    apply(1'b1, 1'b0, 32'h0000_0000, 2'b10, 8'h00, 1'b1);
    check("post_rst_no_bypass", 32'(upd_bht), 32'h3);
    compare_model("post_rst");

    // Random traffic over a handful of indices so bypass hits are frequent.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] pc;
      pc = $urandom;
      pc[10:1] = 10'($urandom_range(0, 3));
      apply(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), pc,
            2'($urandom), 8'($urandom), 1'($urandom));
      compare_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
